// File: rtl/inst_mem_loader_if.sv
//------------------------------------------------------------------------------
// Module   : inst_mem_loader_if
// Brief    : Byte-stream, memory-write and status bundle for inst_mem_loader.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface inst_mem_loader_if;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  // Host / byte-source side
  modport master (
    output start, in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
  );

  // Loader side
  modport slave (
    input  start, in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
  );
endinterface

`default_nettype wire

// File: rtl/inst_mem_loader.sv
//------------------------------------------------------------------------------
// Module   : inst_mem_loader
// Brief    : Boot-time loader: byte stream -> big-endian words -> instruction
//            memory, holding the core until the image is in place.
//            Optional trailing checksum byte enabled by LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module inst_mem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  inst_mem_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_CNT_HI = 3'd0,
    S_CNT_LO = 3'd1,
    S_DATA   = 3'd2,
    S_CHK    = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  localparam logic [16:0] C_MAX_WORDS = 17'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] k_q, k_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] asm_q, asm_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  w_chk_sum;
`endif

  logic        w_ready;
  logic        w_accept;
  logic [15:0] w_count;
  logic [31:0] w_word;
  logic [15:0] w_k_inc;

  assign w_ready  = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                    (state_q == S_DATA)   || (state_q == S_CHK);
  assign w_accept = bus.in_valid && w_ready;
  assign w_count  = {cnt_q[15:8], bus.in_data};
  assign w_word   = {asm_q, bus.in_data};
  assign w_k_inc  = k_q + 16'd1;
`ifdef LOADER_CHECKSUM_EN
  assign w_chk_sum = sum_q + bus.in_data;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    idx_d     = idx_q;
    asm_d     = asm_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    case (state_q)
      S_CNT_HI: begin
        if (w_accept) begin
          cnt_d   = {bus.in_data, 8'h00};
          state_d = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (w_accept) begin
          cnt_d = w_count;
          if ({1'b0, w_count} > C_MAX_WORDS) begin
            state_d = S_ERR;
          end else if (w_count == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_accept) begin
          asm_d = w_word[23:0];
          idx_d = idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          sum_d = sum_q + bus.in_data;
`endif
          // Fourth byte completes the word; the write strobe follows one cycle later.
          if (idx_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_data_d = w_word;
            wr_addr_d = BASE_ADDR + {14'd0, k_q, 2'b00};
            k_d       = w_k_inc;
            if (w_k_inc == cnt_q) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = S_CHK;
`else
              state_d = S_DONE;
`endif
            end
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (w_accept) begin
          state_d = (w_chk_sum == 8'd0) ? S_DONE : S_ERR;
        end
      end
`endif
      S_DONE, S_ERR: begin
        if (bus.start) begin
          state_d = S_CNT_HI;
          cnt_d   = 16'd0;
          k_d     = 16'd0;
          idx_d   = 2'd0;
          asm_d   = 24'd0;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = 8'd0;
`endif
        end
      end
      default: state_d = S_CNT_HI;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_CNT_HI;
      cnt_q     <= 16'd0;
      k_q       <= 16'd0;
      idx_q     <= 2'd0;
      asm_q     <= 24'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= BASE_ADDR;
      wr_data_q <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      sum_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      idx_q     <= idx_d;
      asm_q     <= asm_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  assign bus.in_ready = w_ready;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.done     = (state_q == S_DONE);
  assign bus.error    = (state_q == S_ERR);
  assign bus.cpu_hold = (state_q != S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
//------------------------------------------------------------------------------
// Module   : tb_inst_mem_loader
// Brief    : Directed self-checking bench for inst_mem_loader.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_inst_mem_loader;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   vectors     = 0;
  int   miscompares = 0;

  int          hs_cyc[$];
  int          wr_cyc[$];
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];

  inst_mem_loader_if bus();

  inst_mem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are stamped with the edge on which the byte transfers.
  always @(negedge clk) begin
    if (rst_n && bus.in_valid && bus.in_ready) hs_cyc.push_back(cyc + 1);
    if (bus.wr_en === 1'b1) begin
      wr_cyc.push_back(cyc);
      wr_addr_log.push_back(bus.wr_addr);
      wr_data_log.push_back(bus.wr_data);
    end
  end

  function automatic logic [31:0] log_data(input int i);
    return (i < wr_data_log.size()) ? wr_data_log[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] log_addr(input int i);
    return (i < wr_addr_log.size()) ? wr_addr_log[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic int log_cyc(input int i);
    return (i < wr_cyc.size()) ? wr_cyc[i] : -1;
  endfunction

  task automatic do_reset();
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 1'b0;
    bus.in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) ok = 1'b1;
    end
    if (ok) begin @(posedge clk); #1; end
    bus.in_valid = 1'b0;
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL send_byte_timeout: in_ready=%b required 1", bus.in_ready);
    end
  endtask

  task automatic pulse_start(input logic with_valid);
    bus.start = 1'b1; bus.in_valid = with_valid; bus.in_data = 8'hAA;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'h55;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (bus.in_ready !== 1'b1)  begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    vectors++; if (bus.wr_en !== 1'b0)     begin miscompares++; $display("FAIL reset_wr_en: got %b want 0", bus.wr_en); end
    vectors++; if (bus.wr_addr !== BASE)   begin miscompares++; $display("FAIL reset_wr_addr: got %h want %h", bus.wr_addr, BASE); end
    vectors++; if (bus.wr_data !== 32'd0)  begin miscompares++; $display("FAIL reset_wr_data: got %h want 0", bus.wr_data); end
    vectors++; if (bus.cpu_hold !== 1'b1)  begin miscompares++; $display("FAIL reset_cpu_hold: got %b want 1", bus.cpu_hold); end
    vectors++; if (bus.done !== 1'b0)      begin miscompares++; $display("FAIL reset_done: got %b want 0", bus.done); end
    vectors++; if (bus.error !== 1'b0)     begin miscompares++; $display("FAIL reset_error: got %b want 0", bus.error); end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Shared body of the in_valid-held and in_valid-gapped loads.
  task automatic run_two_word_load(input string tag, input bit gaps);
    logic [7:0]  s [10];
    logic [31:0] exp_d [2];
    int hb, wb;
    s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    exp_d = '{32'h1234_5678, 32'h9ABC_DEF0};
    do_reset();
    hb = hs_cyc.size(); wb = wr_data_log.size();
    foreach (s[i]) send_byte(s[i], gaps ? int'($urandom_range(0, 3)) : 0);
    @(negedge clk);
    vectors++; if (bus.done !== 1'b1)     begin miscompares++; $display("FAIL %s_done: got %b want 1", tag, bus.done); end
    vectors++; if (bus.cpu_hold !== 1'b0) begin miscompares++; $display("FAIL %s_cpu_hold: got %b want 0", tag, bus.cpu_hold); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL %s_in_ready: got %b want 0", tag, bus.in_ready); end
    #1;
    vectors++; if (wr_data_log.size() - wb !== 2) begin miscompares++; $display("FAIL %s_write_count: got %0d want 2", tag, wr_data_log.size() - wb); end
    for (int k = 0; k < 2; k++) begin
      vectors++; if (log_addr(wb + k) !== BASE + 32'(4 * k)) begin miscompares++; $display("FAIL %s_addr%0d: got %h want %h", tag, k, log_addr(wb + k), BASE + 32'(4 * k)); end
      vectors++; if (log_data(wb + k) !== exp_d[k]) begin miscompares++; $display("FAIL %s_data%0d: got %h want %h", tag, k, log_data(wb + k), exp_d[k]); end
      vectors++; if (log_cyc(wb + k) !== hs_cyc[hb + 5 + 4 * k]) begin miscompares++; $display("FAIL %s_latency%0d: write cycle %0d want %0d", tag, k, log_cyc(wb + k), hs_cyc[hb + 5 + 4 * k]); end
    end
  endtask

  task automatic test_basic();
    run_two_word_load("basic", 1'b0);
  endtask

  task automatic test_gaps();
    run_two_word_load("gaps", 1'b1);
  endtask

  task automatic test_overflow();
    int wb;
    do_reset();
    wb = wr_data_log.size();
    send_byte(8'h01, 0); send_byte(8'h01, 0);
    @(negedge clk);
    vectors++; if (bus.error !== 1'b1)    begin miscompares++; $display("FAIL ovf_error: got %b want 1", bus.error); end
    vectors++; if (bus.cpu_hold !== 1'b1) begin miscompares++; $display("FAIL ovf_cpu_hold: got %b want 1", bus.cpu_hold); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL ovf_in_ready: got %b want 0", bus.in_ready); end
    @(posedge clk); #1;
    pulse_start(1'b0);
    @(negedge clk);
    vectors++; if (bus.error !== 1'b0)    begin miscompares++; $display("FAIL ovf_rearm_error: got %b want 0", bus.error); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL ovf_rearm_in_ready: got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
    // Exactly MAX_WORDS is legal
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    @(negedge clk);
    vectors++; if (bus.error !== 1'b0)    begin miscompares++; $display("FAIL max_words_error: got %b want 0", bus.error); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL max_words_in_ready: got %b want 1", bus.in_ready); end
    #1;
    vectors++; if (wr_data_log.size() !== wb) begin miscompares++; $display("FAIL ovf_no_write: got %0d writes want 0", wr_data_log.size() - wb); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] s [8];
    int wb;
    s = '{8'h00, 8'h02, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h01, 8'h02};
    do_reset();
    wb = wr_data_log.size();
    foreach (s[i]) send_byte(s[i], 0);
    rst_n = 1'b0;
    @(negedge clk);
    vectors++; if (bus.wr_en !== 1'b0)    begin miscompares++; $display("FAIL midrst_wr_en: got %b want 0", bus.wr_en); end
    vectors++; if (bus.wr_addr !== BASE)  begin miscompares++; $display("FAIL midrst_wr_addr: got %h want %h", bus.wr_addr, BASE); end
    vectors++; if (bus.wr_data !== 32'd0) begin miscompares++; $display("FAIL midrst_wr_data: got %h want 0", bus.wr_data); end
    vectors++; if (bus.cpu_hold !== 1'b1) begin miscompares++; $display("FAIL midrst_cpu_hold: got %b want 1", bus.cpu_hold); end
    vectors++; if (bus.done !== 1'b0)     begin miscompares++; $display("FAIL midrst_done: got %b want 0", bus.done); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    @(negedge clk); #1;
    vectors++; if (wr_data_log.size() - wb !== 2) begin miscompares++; $display("FAIL midrst_write_count: got %0d want 2", wr_data_log.size() - wb); end
    vectors++; if (log_data(wb) !== 32'hCAFE_BABE) begin miscompares++; $display("FAIL midrst_first_data: got %h want cafebabe", log_data(wb)); end
    vectors++; if (log_addr(wb + 1) !== BASE) begin miscompares++; $display("FAIL midrst_fresh_addr: got %h want %h", log_addr(wb + 1), BASE); end
    vectors++; if (log_data(wb + 1) !== 32'h1122_3344) begin miscompares++; $display("FAIL midrst_fresh_data: got %h want 11223344", log_data(wb + 1)); end
    vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL midrst_fresh_done: got %b want 1", bus.done); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_count();
    int wb, hb;
    do_reset();
    wb = wr_data_log.size();
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    @(negedge clk);
    vectors++; if (bus.done !== 1'b1)     begin miscompares++; $display("FAIL zero_done: got %b want 1", bus.done); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL zero_in_ready: got %b want 0", bus.in_ready); end
    #1;
    vectors++; if (wr_data_log.size() !== wb) begin miscompares++; $display("FAIL zero_no_write: got %0d writes want 0", wr_data_log.size() - wb); end
    @(posedge clk); #1;
    hb = hs_cyc.size();
    pulse_start(1'b1);
    @(negedge clk);
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL zero_rearm_in_ready: got %b want 1", bus.in_ready); end
    vectors++; if (bus.done !== 1'b0)     begin miscompares++; $display("FAIL zero_rearm_done: got %b want 0", bus.done); end
    #1;
    vectors++; if (hs_cyc.size() !== hb) begin miscompares++; $display("FAIL zero_start_no_transfer: got %0d transfers want 0", hs_cyc.size() - hb); end
    @(posedge clk); #1;
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'hA1, 0); send_byte(8'hB2, 0); send_byte(8'hC3, 0); send_byte(8'hD4, 0);
    @(negedge clk); #1;
    vectors++; if (log_data(wb) !== 32'hA1B2_C3D4) begin miscompares++; $display("FAIL zero_followup_data: got %h want a1b2c3d4", log_data(wb)); end
    vectors++; if (log_addr(wb) !== BASE) begin miscompares++; $display("FAIL zero_followup_addr: got %h want %h", log_addr(wb), BASE); end
    @(posedge clk); #1;
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] c [2];
    c = '{8'hF6, 8'hF5};
    for (int r = 0; r < 2; r++) begin
      int wb;
      do_reset();
      wb = wr_data_log.size();
      send_byte(8'h00, 0); send_byte(8'h01, 0);
      send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
      send_byte(c[r], 0);
      @(negedge clk);
      vectors++; if (bus.done !== (r == 0)) begin miscompares++; $display("FAIL chk%0d_done: got %b want %b", r, bus.done, r == 0); end
      vectors++; if (bus.error !== (r == 1)) begin miscompares++; $display("FAIL chk%0d_error: got %b want %b", r, bus.error, r == 1); end
      vectors++; if (bus.cpu_hold !== (r == 1)) begin miscompares++; $display("FAIL chk%0d_cpu_hold: got %b want %b", r, bus.cpu_hold, r == 1); end
      #1;
      vectors++; if (log_data(wb) !== 32'h0102_0304) begin miscompares++; $display("FAIL chk%0d_data: got %h want 01020304", r, log_data(wb)); end
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    test_reset();
    test_basic();
    test_gaps();
    test_overflow();
    test_reset_mid_load();
    test_zero_count();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
